// File: rtl/cpu_pkg.sv
// Shared ISA constants for the ID stage: opcode/funct encodings, ALU control,
// control-vector bit positions and instruction field cracking.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REGIDX = $clog2(NREGS);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_LB    = 6'h20,
    OP_LW    = 6'h23,
    OP_SB    = 6'h28,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_MUL = 6'h18,
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24
  } funct_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_AND = 2'b11
  } aluctrl_e;

  localparam int unsigned CB_BRANCH   = 0;
  localparam int unsigned CB_JUMP     = 1;
  localparam int unsigned CB_MEMREAD  = 2;
  localparam int unsigned CB_MEMTOREG = 3;
  localparam int unsigned CB_MEMWRITE = 4;
  localparam int unsigned CB_ALUSRC   = 5;
  localparam int unsigned CB_REGWRITE = 6;
  localparam int unsigned CB_REGDST   = 7;
  localparam int unsigned CB_WORD     = 8;
  localparam int unsigned CB_WIDTH    = 9;

  typedef logic [0:CB_WIDTH-1] ctrl_t;

  typedef struct packed {
    logic [5:0]        opcode;
    logic [REGIDX-1:0] rs;
    logic [REGIDX-1:0] rt;
    logic [REGIDX-1:0] rd;
    logic [5:0]        funct;
    logic [15:0]       imm16;
    logic [25:0]       target;
  } fields_t;

  function automatic fields_t crack(input logic [31:0] instr);
    fields_t f;
    f.opcode = instr[31:26];
    f.rs     = instr[25:21];
    f.rt     = instr[20:16];
    f.rd     = instr[15:11];
    f.funct  = instr[5:0];
    f.imm16  = instr[15:0];
    f.target = instr[25:0];
    return f;
  endfunction

  function automatic logic [XLEN-1:0] signExt16(input logic [15:0] v);
    return {{(XLEN-16){v[15]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zeroExt26(input logic [25:0] v);
    return {{(XLEN-26){1'b0}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle between IF/ID, WB and ID/EX as seen by the decode stage.
interface decode_stage_if;
  import cpu_pkg::*;

  logic [31:0]       instruction;
  logic [REGIDX-1:0] writeRegisterWB;
  logic [XLEN-1:0]   writeData;
  logic              regWrite;

  logic [XLEN-1:0]   address;
  logic [1:0]        aluCtrl;
  ctrl_t             controlBits;
  logic [XLEN-1:0]   readData1;
  logic [XLEN-1:0]   readData2;
  logic [REGIDX-1:0] writeRegisterID;

  modport master (
    output instruction, writeRegisterWB, writeData, regWrite,
    input  address, aluCtrl, controlBits, readData1, readData2, writeRegisterID
  );

  modport slave (
    input  instruction, writeRegisterWB, writeData, regWrite,
    output address, aluCtrl, controlBits, readData1, readData2, writeRegisterID
  );
endinterface

// File: rtl/decode_stage_reg_file.sv
// 2R1W architectural register file, asynchronous active-low clear, GPR0 hardwired to 0.
// Build option DECODE_WB_BYPASS_EN forwards the WB write to same-cycle reads.
module reg_file
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = cpu_pkg::NREGS,
  parameter int unsigned XLEN  = cpu_pkg::XLEN,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] mem [NREGS];
  logic [XLEN-1:0] stored1;
  logic [XLEN-1:0] stored2;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    stored1 = (ra1 == '0) ? '0 : mem[ra1];
    stored2 = (ra2 == '0) ? '0 : mem[ra2];
  end

`ifdef DECODE_WB_BYPASS_EN
  always_comb begin
    rd1 = (we && (wa != '0) && (wa == ra1)) ? wd : stored1;
    rd2 = (we && (wa != '0) && (wa == ra2)) ? wd : stored2;
  end
`else
  always_comb begin
    rd1 = stored1;
    rd2 = stored2;
  end
`endif

endmodule

// File: rtl/decode_stage.sv
// ID stage: combinational instruction decoder plus the architectural register file.
// Optional WB->ID read bypass is selected with DECODE_WB_BYPASS_EN (see reg_file).
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = cpu_pkg::NREGS,
  parameter int unsigned XLEN  = cpu_pkg::XLEN
) (
  input logic           clock,
  input logic           rst,
  decode_stage_if.slave bus
);

  fields_t   f;
  ctrl_t     cb;
  aluctrl_e  alu;
  logic [XLEN-1:0] addr;
  logic      rtypeKnown;

  assign f = crack(bus.instruction);

  always_comb begin
    cb         = '0;
    alu        = ALU_ADD;
    rtypeKnown = 1'b0;
    addr       = signExt16(f.imm16);
    case (f.opcode)
      OP_RTYPE: begin
        rtypeKnown = 1'b1;
        case (f.funct)
          FN_ADD:  alu = ALU_ADD;
          FN_SUB:  alu = ALU_SUB;
          FN_MUL:  alu = ALU_MUL;
          FN_AND:  alu = ALU_AND;
          default: rtypeKnown = 1'b0;
        endcase
        if (rtypeKnown) begin
          cb[CB_REGWRITE] = 1'b1;
          cb[CB_REGDST]   = 1'b1;
          cb[CB_WORD]     = 1'b1;
        end
      end
      OP_LW, OP_LB: begin
        cb[CB_MEMREAD]  = 1'b1;
        cb[CB_MEMTOREG] = 1'b1;
        cb[CB_ALUSRC]   = 1'b1;
        cb[CB_REGWRITE] = 1'b1;
        cb[CB_WORD]     = (f.opcode == OP_LW);
      end
      OP_SW, OP_SB: begin
        cb[CB_MEMWRITE] = 1'b1;
        cb[CB_ALUSRC]   = 1'b1;
        cb[CB_WORD]     = (f.opcode == OP_SW);
      end
      OP_BEQ: begin
        alu           = ALU_SUB;
        cb[CB_BRANCH] = 1'b1;
      end
      OP_J: begin
        cb[CB_JUMP] = 1'b1;
        addr        = zeroExt26(f.target);
      end
      default: ;
    endcase
  end

  assign bus.address     = addr;
  assign bus.aluCtrl     = alu;
  assign bus.controlBits = cb;
  // Destination is meaningless without a register write, so it is zeroed for hazard logic.
  assign bus.writeRegisterID = !cb[CB_REGWRITE] ? '0 :
                               (cb[CB_REGDST] ? f.rd : f.rt);

  reg_file #(
    .NREGS (NREGS),
    .XLEN  (XLEN)
  ) u_regFile (
    .clock (clock),
    .rst   (rst),
    .we    (bus.regWrite),
    .wa    (bus.writeRegisterWB),
    .wd    (bus.writeData),
    .ra1   (f.rs),
    .ra2   (f.rt),
    .rd1   (bus.readData1),
    .rd2   (bus.readData2)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized instructions/writes
// against a behavioural model of the decode table and register file.
module tb_decode_stage;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock;
  logic rst;
  int   errors;
  int   checks;
  logic [31:0] refRegs [32];

  decode_stage_if dif ();

  decode_stage #(.NREGS(32), .XLEN(32)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (dif.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkR(input int rs, input int rt, input int rd, input int fn);
    logic [31:0] v;
    v = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    return v;
  endfunction

  // Decode table from the ISA description; controlBits index 0 is branch, 8 is word.
  task automatic expDecode(input logic [31:0] ins, output logic [1:0] alu,
                           output logic [0:8] cb, output logic [31:0] addr,
                           output logic [4:0] wr);
    int op;
    int fn;
    op   = int'(ins[31:26]);
    fn   = int'(ins[5:0]);
    cb   = '0;
    alu  = 2'd0;
    addr = (op == 2) ? {6'd0, ins[25:0]} : {{16{ins[15]}}, ins[15:0]};
    if (op == 0) begin
      if (fn == 'h20 || fn == 'h22 || fn == 'h18 || fn == 'h24) begin
        alu = (fn == 'h20) ? 2'd0 : (fn == 'h22) ? 2'd1 : (fn == 'h18) ? 2'd2 : 2'd3;
        cb[6] = 1'b1; cb[7] = 1'b1; cb[8] = 1'b1;
      end
    end else if (op == 'h23 || op == 'h20) begin
      cb[2] = 1'b1; cb[3] = 1'b1; cb[5] = 1'b1; cb[6] = 1'b1;
      cb[8] = (op == 'h23);
    end else if (op == 'h2B || op == 'h28) begin
      cb[4] = 1'b1; cb[5] = 1'b1;
      cb[8] = (op == 'h2B);
    end else if (op == 'h04) begin
      alu = 2'd1; cb[0] = 1'b1;
    end else if (op == 'h02) begin
      cb[1] = 1'b1;
    end
    wr = !cb[6] ? 5'd0 : (cb[7] ? ins[15:11] : ins[20:16]);
  endtask

  function automatic logic [31:0] refRead(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (BYPASS && dif.regWrite && dif.writeRegisterWB == idx) return dif.writeData;
    return refRegs[idx];
  endfunction

  task automatic checkModel(input string tag);
    logic [1:0]  alu;
    logic [0:8]  cb;
    logic [31:0] addr;
    logic [4:0]  wr;
    expDecode(dif.instruction, alu, cb, addr, wr);
    checkVal({tag, ".address"}, dif.address, addr);
    checkVal({tag, ".aluCtrl"}, {30'd0, dif.aluCtrl}, {30'd0, alu});
    checkVal({tag, ".controlBits"}, {23'd0, dif.controlBits}, {23'd0, cb});
    checkVal({tag, ".writeRegisterID"}, {27'd0, dif.writeRegisterID}, {27'd0, wr});
    checkVal({tag, ".readData1"}, dif.readData1, refRead(dif.instruction[25:21]));
    checkVal({tag, ".readData2"}, dif.readData2, refRead(dif.instruction[20:16]));
  endtask

  task automatic drive(input logic [31:0] ins, input logic [4:0] wb,
                       input logic [31:0] wd, input logic we);
    dif.instruction     = ins;
    dif.writeRegisterWB = wb;
    dif.writeData       = wd;
    dif.regWrite        = we;
  endtask

  task automatic cycle();
    @(posedge clock);
    if (rst && dif.regWrite && dif.writeRegisterWB != 5'd0)
      refRegs[dif.writeRegisterWB] = dif.writeData;
    #1;
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] v;
    int pick;
    logic [5:0] ops [8];
    logic [5:0] fns [5];
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h20; ops[3] = 6'h2B;
    ops[4] = 6'h28; ops[5] = 6'h04; ops[6] = 6'h02; ops[7] = 6'($urandom);
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h18; fns[3] = 6'h24; fns[4] = 6'($urandom);
    v = $urandom;
    pick = int'($urandom_range(0, 9));
    v[31:26] = (pick > 7) ? 6'h00 : ops[pick];
    if (v[31:26] == 6'h00) v[5:0] = fns[$urandom_range(0, 4)];
    return v;
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;

    // Writes during reset are ignored
    rst = 1'b0;
    drive(32'd0, 5'd5, 32'hDEAD_BEEF, 1'b1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    drive(mkR(5, 5, 0, 0), 5'd0, 32'd0, 1'b0);
    #2;
    checkModel("reset");
    rst = 1'b1;
    #1;
    checkVal("reset.r5_after_release", dif.readData1, 32'd0);

    drive(32'd0, 5'd3, 32'd7, 1'b1); cycle();
    drive(32'd0, 5'd4, 32'd5, 1'b1); cycle();
    drive(32'h0064_2820, 5'd0, 32'd0, 1'b0);
    #2;
    checkVal("add.readData1", dif.readData1, 32'd7);
    checkVal("add.readData2", dif.readData2, 32'd5);
    checkVal("add.aluCtrl", {30'd0, dif.aluCtrl}, 32'd0);
    checkVal("add.controlBits", {23'd0, dif.controlBits}, {23'd0, 9'b000000111});
    checkVal("add.writeRegisterID", {27'd0, dif.writeRegisterID}, 32'd5);
    checkModel("add");
    cycle();

    drive(32'h8C22_FFFC, 5'd0, 32'd0, 1'b0);
    #2;
    checkVal("lw.address", dif.address, 32'hFFFF_FFFC);
    checkVal("lw.controlBits", {23'd0, dif.controlBits}, {23'd0, 9'b001101101});
    checkVal("lw.writeRegisterID", {27'd0, dif.writeRegisterID}, 32'd2);
    checkModel("lw");
    cycle();

    drive(32'd0, 5'd6, 32'h5A5A_1234, 1'b1); cycle();
    drive(32'hA006_0008, 5'd0, 32'd0, 1'b0);
    #2;
    checkVal("sb.controlBits", {23'd0, dif.controlBits}, {23'd0, 9'b000011000});
    checkVal("sb.writeRegisterID", {27'd0, dif.writeRegisterID}, 32'd0);
    checkVal("sb.readData2", dif.readData2, 32'h5A5A_1234);
    checkVal("sb.address", dif.address, 32'h0000_0008);
    checkModel("sb");
    cycle();

    drive(32'h0800_1234, 5'd0, 32'd0, 1'b0);
    #2;
    checkVal("j.address", dif.address, 32'h0000_1234);
    checkModel("j");
    cycle();

    drive(32'd0, 5'd0, 32'h0000_1234, 1'b1); cycle();
    drive(mkR(0, 0, 0, 'h20), 5'd0, 32'd0, 1'b0);
    #2;
    checkVal("r0.readData1", dif.readData1, 32'd0);
    cycle();

    drive(32'd0, 5'd7, 32'h0000_0011, 1'b1); cycle();
    drive(mkR(7, 0, 0, 'h20), 5'd7, 32'h0000_00AA, 1'b1);
    #2;
    checkVal("r7.same_cycle", dif.readData1, BYPASS ? 32'h0000_00AA : 32'h0000_0011);
    checkModel("r7");
    cycle();
    drive(mkR(7, 0, 0, 'h20), 5'd0, 32'd0, 1'b0);
    #2;
    checkVal("r7.next_cycle", dif.readData1, 32'h0000_00AA);
    cycle();

    for (int n = 0; n < 300; n++) begin
      drive(randInstr(), 5'($urandom), $urandom, 1'($urandom));
      #2;
      checkModel("rand");
      cycle();
    end

    // Asynchronous reset arriving mid-write must win
    drive(mkR(3, 4, 0, 'h20), 5'd9, 32'h0000_CAFE, 1'b1);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
    #1;
    checkVal("midreset.readData1", dif.readData1, 32'd0);
    checkVal("midreset.readData2", dif.readData2, 32'd0);
    cycle();
    drive(mkR(9, 6, 0, 'h20), 5'd0, 32'd0, 1'b0);
    rst = 1'b1;
    #2;
    checkVal("midreset.r9", dif.readData1, 32'd0);
    checkModel("midreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage in-order pipeline; sits between the IF/ID and ID/EX pipeline registers.
- Cracks the 32-bit instruction and generates ALU control, 9-bit control vector, extended immediate/address and destination register index.
- Owns the 32x32 architectural register file: two combinational reads, one clocked write from WB.

Parameters:
- NREGS, 32, register count (index width 5 bits).
- XLEN, 32, datapath width.

Ports:
- clock  in  1  single system clock; register-file write on rising edge.
- rst  in  1  asynchronous, active-low reset.
- instruction  in  32  instruction from IF/ID.
- writeRegisterWB  in  5  WB destination index.
- writeData  in  32  WB data.
- regWrite  in  1  WB write enable.
- address  out  32  extended immediate / jump target field.
- aluCtrl  out  2  ALU op: 00 ADD, 01 SUB, 10 MUL, 11 AND.
- controlBits  out  [0:8]  0 branch, 1 jump, 2 memRead, 3 memToReg, 4 memWrite, 5 aluSrc (1 = immediate op2), 6 regWrite, 7 regDst, 8 word (1 = 32-bit, 0 = byte).
- readData1  out  32  GPR[rs].
- readData2  out  32  GPR[rt].
- writeRegisterID  out  5  destination: rd if regDst, else rt.

Behaviour:
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm16 [15:0], target [25:0].
- Decode is purely combinational; zero-cycle latency from instruction to all outputs except register write.
- R-type (opcode 0x00):
  - funct 0x20 ADD -> aluCtrl 00; 0x22 SUB -> 01; 0x18 MUL -> 10; 0x24 AND -> 11.
  - controlBits: regWrite=1, regDst=1, word=1, all others 0.
  - Unknown funct behaves as NOP.
- LW 0x23 / LB 0x20: aluCtrl 00; memRead, memToReg, aluSrc, regWrite = 1; regDst 0; word 1 for LW, 0 for LB.
- SW 0x2B / SB 0x28: aluCtrl 00; memWrite, aluSrc = 1; regWrite 0; word as for loads.
- BEQ 0x04: aluCtrl 01; branch 1; aluSrc 0.
- J 0x02: jump 1.
- address:
  - sign-extended imm16 for all non-jump opcodes;
  - for J, zero-extended target.
- Unknown opcode = NOP: controlBits all 0, aluCtrl 00, address still computed.
- Register file, asynchronous clear:
  - while rst=0, every GPR is 0x0000_0000 and writes are ignored;
  - reset may assert mid-write and wins.
- Register file write:
  - on posedge clock when rst=1 and regWrite=1 and writeRegisterWB != 0, GPR[writeRegisterWB] <= writeData;
  - GPR0 is never written and always reads 0.
- Reads are combinational from current array contents. Same-cycle write/read of the same register returns the old value (without the optional bypass).
- writeRegisterID is forced to 0 when regWrite control is 0.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: when regWrite=1, writeRegisterWB != 0 and writeRegisterWB equals rs (resp. rt), readData1 (resp. readData2) returns writeData combinationally in the same cycle.
- Undefined: reads return stored array contents only; same-cycle write shows up the next cycle.

Decomposition:
- Package cpu_pkg holds:
  - opcode and funct constants;
  - aluCtrl encodings;
  - controlBits index constants (CB_BRANCH..CB_WORD);
  - XLEN and NREGS.
- One natural sub-module: reg_file (32x32, 2R1W, async active-low clear), instantiated inside decode_stage alongside the combinational control decoder.

Test Plan:
- Reset: hold rst=0, pulse clock with regWrite=1, writeRegisterWB=5, writeData=0xDEAD_BEEF -> after release readData of r5 = 0.
- Write/read: write r3=0x0000_0007 and r4=0x0000_0005; then ADD r5,r3,r4 (0x0064_2820):
  - readData1=7, readData2=5;
  - aluCtrl=00, controlBits=9'b000000111, writeRegisterID=5.
- LW r2,-4(r1) (0x8C22_FFFC):
  - address=0xFFFF_FFFC;
  - controlBits memRead/memToReg/aluSrc/regWrite/word=1;
  - writeRegisterID=2.
- SB r6,8(r0) (0xA006_0008):
  - memWrite=1, aluSrc=1, word=0, regWrite=0;
  - writeRegisterID=0, readData2=GPR6.
- r0 protection: regWrite=1, writeRegisterWB=0, writeData=0x1234 -> readData1 with rs=0 stays 0.
- Same-cycle write/read of r7 with writeData=0xAA:
  - readData1=0xAA in the same cycle when DECODE_WB_BYPASS_EN is defined;
  - old value when it is not defined.
